// File: rtl/bus_write_logger_pkg.sv
// Shared bus constants, trace entry layout and helpers for bus_write_logger.
// Entry layout widens with a timestamp field when TRACE_TIMESTAMP_EN is defined.
package bus_write_logger_pkg;

    localparam int   BUS_ADDR_W = 16;
    localparam int   BUS_DATA_W = 8;
    localparam logic RW_READ    = 1'b1;
    localparam logic RW_WRITE   = 1'b0;
`ifdef TRACE_TIMESTAMP_EN
    localparam int   TS_W       = 16;
`endif

    typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]       ts;
`endif
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data;
    } trace_entry_t;

    localparam int TRACE_W = $bits(trace_entry_t);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bus_write_logger_if.sv
// CPU bus and trace-drain signals of bus_write_logger; master = CPU/consumer, slave = logger.
// trace_time exists only when TRACE_TIMESTAMP_EN is defined.
interface bus_write_logger_if;
    import bus_write_logger_pkg::*;

    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic                  rw;
    logic                  clk2;
    logic [BUS_DATA_W-1:0] rdata;
    logic                  sel;
    logic                  trace_valid;
    logic                  trace_ready;
    logic [BUS_ADDR_W-1:0] trace_addr;
    logic [BUS_DATA_W-1:0] trace_data;
    logic [7:0]            overflow_cnt;
`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0]       trace_time;
`endif

    modport master (
`ifdef TRACE_TIMESTAMP_EN
        input  trace_time,
`endif
        output addr, wdata, rw, clk2, trace_ready,
        input  rdata, sel, trace_valid, trace_addr, trace_data, overflow_cnt
    );

    modport slave (
`ifdef TRACE_TIMESTAMP_EN
        output trace_time,
`endif
        input  addr, wdata, rw, clk2, trace_ready,
        output rdata, sel, trace_valid, trace_addr, trace_data, overflow_cnt
    );

endinterface

// File: rtl/bus_write_logger_trace_fifo.sv
// Synchronous trace FIFO with wrap-bit pointers and a saturating dropped-push counter.
// A push into a full FIFO succeeds only when a pop retires the head in the same cycle.
module trace_fifo
    import bus_write_logger_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [7:0]       o_overflow_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [7:0]       r_ovf;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    // Head reads as zero while empty so stale storage never leaks onto the port.
    assign o_data         = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_overflow_cnt = r_ovf;

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push_ok)           r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop_ok)            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (i_push & ~w_push_ok) r_ovf    <= sat_inc8(r_ovf);
        end
    end

endmodule

// File: rtl/bus_write_logger.sv
// Write-side 6502 bus responder: phi2-edge store detect, windowed RAM, trace FIFO.
// Define TRACE_TIMESTAMP_EN to stamp each trace entry with a free-running cycle count.
module bus_write_logger
    import bus_write_logger_pkg::*;
#(
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR  = 16'h0000,
    parameter int                    ADDR_BITS  = 8,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    bus_write_logger_if.slave bus
);
    localparam int unsigned WIN_SIZE = 1 << ADDR_BITS;

    logic                  r_clk2_q;
    logic [BUS_DATA_W-1:0] r_ram [WIN_SIZE];
    logic                  w_st;
    logic                  w_hit;
    logic                  w_sel;
    logic                  w_empty;
    logic [BUS_ADDR_W-1:0] w_offset;
    trace_entry_t          w_push_entry;
    trace_entry_t          w_head;

    // clk2_q resets high so a phi2 already high at reset release is not a rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_clk2_q <= 1'b1;
        else       r_clk2_q <= bus.clk2;
    end

    assign w_st     = bus.clk2 & ~r_clk2_q & (bus.rw == RW_WRITE);
    assign w_offset = bus.addr - BASE_ADDR;
    assign w_hit    = 32'(w_offset) < WIN_SIZE;
    assign w_sel    = w_hit & (bus.rw == RW_READ);

    always_ff @(posedge clk) begin
        if (w_st && w_hit) r_ram[w_offset[ADDR_BITS-1:0]] <= bus.wdata;
    end

    assign bus.sel   = w_sel;
    assign bus.rdata = w_sel ? r_ram[w_offset[ADDR_BITS-1:0]] : 8'hff;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ts <= '0;
        else       r_ts <= r_ts + 16'd1;
    end
`endif

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.addr = bus.addr;
        w_push_entry.data = bus.wdata;
`ifdef TRACE_TIMESTAMP_EN
        w_push_entry.ts   = r_ts;
`endif
    end

    trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk            (clk),
        .rst            (reset),
        .i_push         (w_st),
        .i_data         (w_push_entry),
        .i_pop          (bus.trace_ready),
        .o_data         (w_head),
        .o_empty        (w_empty),
        .o_overflow_cnt (bus.overflow_cnt)
    );

    assign bus.trace_valid = ~w_empty;
    assign bus.trace_addr  = w_head.addr;
    assign bus.trace_data  = w_head.data;
`ifdef TRACE_TIMESTAMP_EN
    assign bus.trace_time  = w_head.ts;
`endif

endmodule
